// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES / Triple-DES control path.
//
// Contents:
//   state_t     - sequencer state encoding (IDLE / RUN / DONE)
//   DES_ROUNDS  - last round_count value in one DES pass
//   TDES_PASSES - number of DES passes in one Triple-DES block
//   ROUND_W     - width of the round counter
//   KEY_W       - width of the pass (key) counter
// ---------------------------------------------------------------------------
package des_pkg;

  localparam int DES_ROUNDS  = 16;
  localparam int TDES_PASSES = 3;
  localparam int ROUND_W     = 5;
  localparam int KEY_W       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/des_round_sequencer.sv
// ---------------------------------------------------------------------------
// des_round_sequencer
// Control sequencer for a single- or triple-pass DES engine. A start request
// taken in IDLE loads the block, steps the round counter through 0..ROUNDS
// once per pass, steps the pass counter once per pass, and finishes with a
// single DONE cycle carrying the result-valid pulse.
//
// Parameters:
//   PASSES - DES passes per block (1 or 3)
//   ROUNDS - last round_count value of a pass (a pass lasts ROUNDS+1 cycles)
//
// Ports:
//   clk          in   clock, rising-edge active
//   n_rst        in   asynchronous active-low reset
//   start        in   begin one block (only looked at in IDLE)
//   decrypt      in   block mode, 0 = EDE encrypt, 1 = DED decrypt
//   hold         in   stall request while running (DES_SEQ_HOLD_EN only)
//   round_count  out  current round index
//   key_count    out  current pass index
//   cnt_rollover out  last round of a pass
//   key_rollover out  last round of the last pass
//   reverse      out  reversed key schedule select
//   load_block   out  capture the input block (same cycle as accepted start)
//   busy         out  sequencer is in RUN or DONE
//   done         out  one-cycle result-valid pulse
//
// Build option:
//   DES_SEQ_HOLD_EN - adds the hold input that freezes the sequencer in RUN.
// ---------------------------------------------------------------------------
module des_round_sequencer
  import des_pkg::*;
#(
  parameter int PASSES = TDES_PASSES,
  parameter int ROUNDS = DES_ROUNDS
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               decrypt,
`ifdef DES_SEQ_HOLD_EN
  input  logic               hold,
`endif
  output logic [ROUND_W-1:0] round_count,
  output logic [KEY_W-1:0]   key_count,
  output logic               cnt_rollover,
  output logic               key_rollover,
  output logic               reverse,
  output logic               load_block,
  output logic               busy,
  output logic               done
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);
  localparam logic [KEY_W-1:0]   LAST_KEY   = KEY_W'(PASSES - 1);
  localparam logic [KEY_W-1:0]   MIDDLE_KEY = KEY_W'(1);

  state_t               r_state;
  logic [ROUND_W-1:0]   r_round;
  logic [KEY_W-1:0]     r_key;
  logic                 r_mode;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_hold;
  logic                 w_cnt_roll;
  logic                 w_last_pass;

  // The stall only has meaning while rounds are being stepped; in IDLE and
  // DONE it is masked so a stuck hold can never block start-up or completion.
`ifdef DES_SEQ_HOLD_EN
  assign w_hold = hold && (r_state == RUN);
`else
  assign w_hold = 1'b0;
`endif

  // End-of-pass and end-of-block are decoded straight from the registers so
  // the key generator sees them in the same cycle as the final round index.
  assign w_last_pass  = (r_key == LAST_KEY);
  assign w_cnt_roll   = (r_state == RUN) && (r_round == LAST_ROUND) && !w_hold;
  assign cnt_rollover = w_cnt_roll;
  assign key_rollover = w_cnt_roll && w_last_pass;

  // load_block fires in the cycle the start is accepted, so it cannot be a
  // register; it is qualified by n_rst so reset silences it even with start
  // held high.
  assign load_block = n_rst && (r_state == IDLE) && start && !w_hold;

  // The middle pass of a triple-DES block runs the opposite key direction.
  // In IDLE the live decrypt input is passed through so the key generator
  // is already pointed the right way when round 0 begins.
  assign reverse = (r_state == IDLE) ? decrypt
                                     : ((r_key == MIDDLE_KEY) ^ r_mode);

  assign round_count = r_round;
  assign key_count   = r_key;
  assign busy        = r_busy;
  assign done        = r_done;

  // Main sequencer. Round and pass counters live here alongside the state so
  // that every counter update is tied to the transition that causes it; busy
  // and done are registered copies of the state that the FSM is entering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_round <= '0;
      r_key   <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_round <= '0;
          r_key   <= '0;
          r_done  <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_mode  <= decrypt;
            r_busy  <= 1'b1;
          end
        end

        RUN: begin
          if (!w_hold) begin
            if (w_cnt_roll) begin
              r_round <= '0;
              if (w_last_pass) begin
                r_key   <= '0;
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_key <= r_key + KEY_W'(1);
              end
            end else begin
              r_round <= r_round + ROUND_W'(1);
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_round <= '0;
          r_key   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_round <= '0;
          r_key   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_des_round_sequencer
// Self-checking bench for des_round_sequencer at the default Triple-DES
// configuration. Block vectors come from a table; pulse events expected for
// each block are queued when start is driven and retired as the DUT raises
// them. Reset, held-start and stall behaviour use hand-written sequences.
// The stall sequence is built only when DES_SEQ_HOLD_EN is defined.
// ---------------------------------------------------------------------------
module tb_des_round_sequencer;

  localparam int P   = 3;
  localparam int R   = 16;
  localparam int LAT = P * (R + 1) + 1;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       decrypt;
`ifdef DES_SEQ_HOLD_EN
  logic       hold;
`endif
  logic [4:0] round_count;
  logic [1:0] key_count;
  logic       cnt_rollover;
  logic       key_rollover;
  logic       reverse;
  logic       load_block;
  logic       busy;
  logic       done;

  typedef struct {
    logic       decrypt;
    int         pokeCycle;
    logic [2:0] expRev;
  } vec_t;

  typedef struct {
    int   cyc;
    logic cnt;
    logic key;
    logic dn;
  } event_t;

  vec_t   vecs[4];
  event_t sbQ[$];
  int     checks;
  int     errors;

  des_round_sequencer #(
    .PASSES(P),
    .ROUNDS(R)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .decrypt     (decrypt),
`ifdef DES_SEQ_HOLD_EN
    .hold        (hold),
`endif
    .round_count (round_count),
    .key_count   (key_count),
    .cnt_rollover(cnt_rollover),
    .key_rollover(key_rollover),
    .reverse     (reverse),
    .load_block  (load_block),
    .busy        (busy),
    .done        (done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a hung sequence can never stall the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Retires one queued event whenever any pulse output is seen high.
  task automatic scoreEvents(input int cyc);
    event_t e;
    if (cnt_rollover || key_rollover || done) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: cycle %0d flags %b%b%b, none expected",
                 cyc, cnt_rollover, key_rollover, done);
      end else begin
        e = sbQ.pop_front();
        checkOutput("event_cycle", cyc, e.cyc);
        checkOutput("event_flags", {cnt_rollover, key_rollover, done},
                    {e.cnt, e.key, e.dn});
      end
    end
  endtask

  // Runs one full block from IDLE. Called just after a rising edge; returns
  // just after a rising edge with the DUT back in IDLE.
  task automatic applyStimulus(input vec_t v);
    int p;
    event_t e;
    decrypt = v.decrypt;
    start   = 1'b1;
    @(negedge clk);
    checkOutput("load_block_c0", load_block, 1);
    checkOutput("busy_c0", busy, 0);
    checkOutput("reverse_idle", reverse, v.decrypt);
    for (int k = 0; k < P; k++) begin
      e.cyc = (k + 1) * (R + 1);
      e.cnt = 1'b1;
      e.key = (k == P - 1);
      e.dn  = 1'b0;
      sbQ.push_back(e);
    end
    e.cyc = LAT;
    e.cnt = 1'b0;
    e.key = 1'b0;
    e.dn  = 1'b1;
    sbQ.push_back(e);
    for (int cyc = 1; cyc <= LAT + 8; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == v.pokeCycle) begin
        start   = 1'b1;
        decrypt = ~v.decrypt;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      scoreEvents(cyc);
      checkOutput("load_block_run", load_block, 0);
      if (cyc < LAT) begin
        p = (cyc - 1) / (R + 1);
        checkOutput("round_count", round_count, (cyc - 1) % (R + 1));
        checkOutput("key_count", key_count, p);
        checkOutput("reverse_run", reverse, v.expRev[p]);
        checkOutput("busy_run", busy, 1);
      end else if (cyc == LAT) begin
        checkOutput("busy_done", busy, 1);
        checkOutput("round_count_done", round_count, 0);
        checkOutput("key_count_done", key_count, 0);
      end else begin
        checkOutput("busy_idle", busy, 0);
        checkOutput("round_count_idle", round_count, 0);
        checkOutput("reverse_idle_after", reverse, decrypt);
      end
    end
    checkOutput("sb_empty", sbQ.size(), 0);
    sbQ.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int doneCyc[$];
    int doneCount;
    int waitCyc;
    checks  = 0;
    errors  = 0;
    n_rst   = 1'b0;
    start   = 1'b1;
    decrypt = 1'b0;
`ifdef DES_SEQ_HOLD_EN
    hold    = 1'b0;
`endif

    vecs[0] = '{decrypt: 1'b0, pokeCycle: -1, expRev: 3'b010};
    vecs[1] = '{decrypt: 1'b1, pokeCycle: -1, expRev: 3'b101};
    vecs[2] = '{decrypt: 1'b0, pokeCycle: 10, expRev: 3'b010};
    vecs[3] = '{decrypt: 1'b1, pokeCycle: 30, expRev: 3'b101};

    // Reset state, including start held high while reset is asserted.
    #13;
    checkOutput("rst_load_block", load_block, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_round_count", round_count, 0);
    checkOutput("rst_key_count", key_count, 0);
    checkOutput("rst_cnt_rollover", cnt_rollover, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven blocks.
    for (int i = 0; i < 4; i++) begin
      $display("[TB] block vector %0d", i);
      applyStimulus(vecs[i]);
    end

    // Reset mid-block at round 7 of pass 1.
    $display("[TB] mid-block reset");
    decrypt = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= (R + 1) + 8; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
    end
    checkOutput("pre_rst_round", round_count, 7);
    checkOutput("pre_rst_key", key_count, 1);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("arst_round_count", round_count, 0);
    checkOutput("arst_key_count", key_count, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_cnt_rollover", cnt_rollover, 0);
    checkOutput("arst_key_rollover", key_rollover, 0);
    checkOutput("arst_load_block", load_block, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    doneCount = 0;
    for (int cyc = 0; cyc < LAT + 8; cyc++) begin
      @(negedge clk);
      if (done) doneCount++;
      @(posedge clk);
      #1;
    end
    checkOutput("no_done_after_rst", doneCount, 0);
    checkOutput("idle_after_rst", busy, 0);
    applyStimulus(vecs[0]);

    // start held high: a new block follows each DONE with no gap.
    $display("[TB] held start");
    decrypt = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    checkOutput("held_load_c0", load_block, 1);
    for (int cyc = 1; cyc <= 3 * (LAT + 1) - 1; cyc++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (done) doneCyc.push_back(cyc);
      if (cyc == LAT + 1) checkOutput("held_reload", load_block, 1);
    end
    checkOutput("held_done_count", doneCyc.size(), 3);
    for (int k = 0; k < doneCyc.size(); k++)
      checkOutput("held_done_cycle", doneCyc[k], LAT + k * (LAT + 1));
    @(posedge clk);
    #1;
    start   = 1'b0;
    waitCyc = 0;
    while (busy && waitCyc < 2 * LAT) begin
      @(posedge clk);
      #1;
      waitCyc++;
    end
    checkOutput("held_drain_idle", busy, 0);

`ifdef DES_SEQ_HOLD_EN
    // Five-cycle stall while round_count is 3 pushes done out by five.
    $display("[TB] hold stall");
    decrypt = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    doneCount = -1;
    for (int cyc = 1; cyc <= LAT + 15; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      hold  = (cyc >= 4 && cyc <= 8);
      @(negedge clk);
      if (cyc >= 4 && cyc <= 8) begin
        checkOutput("hold_round_count", round_count, 3);
        checkOutput("hold_cnt_rollover", cnt_rollover, 0);
      end
      if (done && doneCount < 0) doneCount = cyc;
    end
    hold = 1'b0;
    checkOutput("hold_done_cycle", doneCount, LAT + 5);
    @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

Interface
REQ-001 SHALL have parameter PASSES, default 3, giving the number of DES passes per block; only 1 and 3 are legal.
REQ-002 SHALL have parameter ROUNDS, default 16, giving the last round_count value per pass; each pass lasts ROUNDS+1 cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to process one block; sampled only in IDLE.
REQ-006 SHALL have port decrypt, input, 1, block mode (0 = EDE encrypt, 1 = DED decrypt); captured with start.
REQ-007 SHALL have port round_count, output, 5, current round index to the key generator and datapath.
REQ-008 SHALL have port key_count, output, 2, current pass index.
REQ-009 SHALL have port cnt_rollover, output, 1, end-of-pass pulse.
REQ-010 SHALL have port key_rollover, output, 1, end-of-block pulse.
REQ-011 SHALL have port reverse, output, 1, reversed-key select for the key generator.
REQ-012 SHALL have port load_block, output, 1, one-cycle pulse telling the datapath to capture its input block.
REQ-013 SHALL have port busy, output, 1, high while state is RUN or DONE.
REQ-014 SHALL have port done, output, 1, one-cycle result-valid pulse.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 IDLE with start=1 SHALL go to RUN, capture decrypt into mode_q, and assert load_block in that same cycle; start=0 SHALL stay in IDLE.
REQ-017 In IDLE, round_count and key_count SHALL be held at 0.
REQ-018 In RUN, round_count SHALL increment by 1 each cycle and wrap ROUNDS->0.
REQ-019 cnt_rollover SHALL equal (state==RUN && round_count==ROUNDS), combinationally from registers.
REQ-020 On cnt_rollover, key_count SHALL increment; if key_count==PASSES-1 it SHALL go to 0 instead.
REQ-021 key_rollover SHALL equal cnt_rollover && key_count==PASSES-1; the next state SHALL then be DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1 and counters at 0, then go to IDLE.
REQ-023 Latency from start to done SHALL be PASSES*(ROUNDS+1)+1 cycles (52 at defaults).
REQ-024 reverse SHALL equal (key_count==1) XOR mode_q in RUN and DONE, and decrypt XOR 0 in IDLE; it SHALL be valid whenever round_count==0.
REQ-025 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 start held high continuously SHALL begin a new block on the first IDLE cycle after each DONE.
REQ-027 With PASSES=1, every cnt_rollover SHALL also be a key_rollover.

Reset
REQ-028 n_rst low SHALL immediately force the following, regardless of clk: state IDLE, round_count 0, key_count 0, mode_q 0, cnt_rollover 0, key_rollover 0, load_block 0, done 0, busy 0.
REQ-029 Reset asserted mid-block SHALL abandon the block with no done pulse; the first start after release SHALL behave as a fresh block.

Configuration
REQ-030 With macro DES_SEQ_HOLD_EN defined, the module SHALL add input hold (1 bit).
REQ-031 With DES_SEQ_HOLD_EN defined and hold=1 in RUN, round_count, key_count and state SHALL freeze, and cnt_rollover, key_rollover and load_block SHALL be forced to 0.
REQ-032 With DES_SEQ_HOLD_EN defined, hold SHALL be ignored in IDLE and DONE.
REQ-033 Without DES_SEQ_HOLD_EN, there SHALL be no hold port and the sequencer SHALL never stall.

Structure
REQ-034 A shared package des_pkg SHALL hold the state enum (IDLE/RUN/DONE), DES_ROUNDS=16, TDES_PASSES=3 and the round_count/key_count widths.
REQ-035 The module SHALL be flat, with no sub-module; the round and pass counters SHALL be inline registers.

Verification
REQ-036 Reset release, then start=1 for 1 cycle with decrypt=0 -> load_block the same cycle; cnt_rollover at cycles 17 and 34; key_rollover at cycle 51; done at cycle 52.
REQ-037 Same stimulus as REQ-036 -> reverse=0,1,0 during passes 0,1,2; with decrypt=1 -> reverse=1,0,1.
REQ-038 start pulsed at cycle 10 of a block -> no effect; done still occurs at cycle 52.
REQ-039 n_rst pulsed low at round_count=7, key_count=1 -> all outputs 0 asynchronously; no done; the next start gives done 52 cycles later.
REQ-040 start held high -> done pulses every 53 cycles.
REQ-041 With DES_SEQ_HOLD_EN defined, hold=1 for 5 cycles at round_count=3 -> round_count stays 3 throughout; done arrives at cycle 57.
